// File: rtl/run_mon_pkg.sv
// rtl/run_mon_pkg.sv - shared state encoding and saturating-increment helper for run_length_monitor
package run_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LATCH = 2'd2,
    COOL  = 2'd3
  } state_t;

  // Increment v by one unless it has already reached maxv.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
    return (v >= maxv) ? maxv : (v + 32'd1);
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter with synchronous clear, load-zero and enable
module sat_cnt
  import run_mon_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             zero,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [31:0] MAXV = 32'((33'd1 << WIDTH) - 33'd1);

  // Clear and load-zero win over increment; increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr || zero) begin
      q <= '0;
    end else if (en) begin
      q <= WIDTH'(sat_inc(32'(q), MAXV));
    end
  end

endmodule

// File: rtl/run_length_monitor.sv
// rtl/run_length_monitor.sv - high-run length monitor with hit pulse, hit counter and cooldown; optional max_run via RUN_MAX_EN
module run_length_monitor
  import run_mon_pkg::*;
#(
  parameter int THRESH   = 4,
  parameter int COOLDOWN = 2,
  parameter int CNT_W    = 8,
  parameter int HIT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             clr,
  output logic             hit,
  output logic [CNT_W-1:0] run_len,
  output logic [HIT_W-1:0] hit_cnt,
  output logic             busy
`ifdef RUN_MAX_EN
  ,
  output logic [CNT_W-1:0] max_run
`endif
);

  localparam int COOL_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

  state_t            state;
  logic [COOL_W-1:0] cool_cnt;
  logic              counting;
  logic              hit_set;
  logic              run_inc;
  logic              run_zero;

  // Decode counter controls and the qualifying edge from the current state and sample.
  always_comb begin
    counting = (state == IDLE) || (state == RUN);
    hit_set  = counting && in && (run_len == CNT_W'(THRESH - 1));
    run_inc  = in && (state != COOL);
    run_zero = !run_inc;
  end

  // Run/cooldown FSM with registered hit pulse; clr forces IDLE ahead of the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cool_cnt <= '0;
      hit      <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      cool_cnt <= '0;
      hit      <= 1'b0;
    end else begin
      hit <= hit_set;
      case (state)
        IDLE, RUN: begin
          if (in) begin
            state <= hit_set ? LATCH : RUN;
          end else begin
            state <= IDLE;
          end
        end
        LATCH: begin
          if (!in) begin
            if (COOLDOWN == 0) begin
              state <= IDLE;
            end else begin
              state    <= COOL;
              cool_cnt <= COOL_W'(COOLDOWN);
            end
          end
        end
        COOL: begin
          if (cool_cnt <= COOL_W'(1)) begin
            state    <= IDLE;
            cool_cnt <= '0;
          end else begin
            cool_cnt <= cool_cnt - COOL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  sat_cnt #(.WIDTH(CNT_W)) u_run_len (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .zero (run_zero),
    .en   (run_inc),
    .q    (run_len)
  );

  sat_cnt #(.WIDTH(HIT_W)) u_hit_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .zero (1'b0),
    .en   (hit_set),
    .q    (hit_cnt)
  );

`ifdef RUN_MAX_EN
  logic [CNT_W-1:0] run_len_nxt;
  logic             max_en;

  // run_len only ever grows by one, so max_run can follow it with a plain increment.
  always_comb begin
    run_len_nxt = CNT_W'(sat_inc(32'(run_len), 32'((33'd1 << CNT_W) - 33'd1)));
    max_en      = run_inc && (run_len_nxt > max_run);
  end

  sat_cnt #(.WIDTH(CNT_W)) u_max_run (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .zero (1'b0),
    .en   (max_en),
    .q    (max_run)
  );
`endif

endmodule
